// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - channel, flush and register-file write bundle for wb_arbiter
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 8
`endif
`ifndef INT_ASSERT
`define INT_ASSERT 1'b1
`endif

interface wb_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = `REG_DATA_WIDTH,
    parameter int AW  = `REG_ADDR_WIDTH,
    parameter int IDW = `COMMIT_ID_WIDTH
) ();
    logic [NCH-1:0]     ch_valid_i;
    logic [NCH-1:0]     ch_ready_o;
    logic [NCH*DW-1:0]  ch_wdata_i;
    logic [NCH*AW-1:0]  ch_waddr_i;
    logic [NCH-1:0]     ch_long_i;
    logic [NCH*IDW-1:0] ch_id_i;
    logic               flush_i;
    logic               reg_we_o;
    logic [AW-1:0]      reg_waddr_o;
    logic [DW-1:0]      reg_wdata_o;
    logic               commit_valid_o;
    logic [IDW-1:0]     commit_id_o;

    modport master (
        output ch_valid_i, ch_wdata_i, ch_waddr_i, ch_long_i, ch_id_i, flush_i,
        input  ch_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, commit_valid_o, commit_id_o
    );

    modport slave (
        input  ch_valid_i, ch_wdata_i, ch_waddr_i, ch_long_i, ch_id_i, flush_i,
        output ch_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, commit_valid_o, commit_id_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - N-channel write-back arbiter with anti-starvation; WBU_RR_EN selects round-robin
`ifndef INT_ASSERT
`define INT_ASSERT 1'b1
`endif

module wb_arbiter #(
    parameter int NCH          = 4,
    parameter int DW           = `REG_DATA_WIDTH,
    parameter int AW           = `REG_ADDR_WIDTH,
    parameter int IDW          = `COMMIT_ID_WIDTH,
    parameter int STARVE_LIMIT = 7
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);
    localparam int AGEW = $clog2(STARVE_LIMIT + 1);
    localparam int PW   = $clog2(NCH);
    localparam logic [AGEW-1:0] AGE_MAX = AGEW'(STARVE_LIMIT);

    logic               flush;
    logic [NCH-1:0]     buf_valid;
    logic [DW-1:0]      buf_wdata [NCH];
    logic [AW-1:0]      buf_waddr [NCH];
    logic               buf_long  [NCH];
    logic [IDW-1:0]     buf_id    [NCH];
    logic [AGEW-1:0]    age       [NCH];
    logic [NCH-1:0]     starving;
    logic [NCH-1:0]     grant;
    logic [NCH-1:0]     ch_ready;
    logic [PW-1:0]      gidx;
    logic               any_grant;
    logic               reg_we;
    logic [AW-1:0]      reg_waddr;
    logic [DW-1:0]      reg_wdata;
    logic               commit_valid;
    logic [IDW-1:0]     commit_id;

    assign flush    = (bus.flush_i == `INT_ASSERT);
    assign ch_ready = flush ? '0 : (~buf_valid | grant);

    always_comb begin
        starving = '0;
        for (int c = 0; c < NCH; c++) begin
            starving[c] = buf_valid[c] && (age[c] == AGE_MAX);
        end
    end

`ifdef WBU_RR_EN
    logic [PW-1:0] rr_ptr;
`endif

    // Loops run from the top index down so the last hit is the winner.
    always_comb begin
`ifdef WBU_RR_EN
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        sum = '0;
        idx = '0;
`endif
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        if (!flush) begin
            if (|starving) begin
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (starving[c]) gidx = PW'(c);
                end
                any_grant = 1'b1;
            end else begin
`ifdef WBU_RR_EN
                for (int k = NCH - 1; k >= 0; k--) begin
                    sum = {1'b0, rr_ptr} + (PW+1)'(k);
                    if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
                    idx = sum[PW-1:0];
                    if (buf_valid[idx]) begin
                        gidx      = idx;
                        any_grant = 1'b1;
                    end
                end
`else
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (buf_valid[c]) begin
                        gidx      = PW'(c);
                        any_grant = 1'b1;
                    end
                end
`endif
            end
            if (any_grant) grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                buf_valid[c] <= 1'b0;
                buf_wdata[c] <= '0;
                buf_waddr[c] <= '0;
                buf_long[c]  <= 1'b0;
                buf_id[c]    <= '0;
                age[c]       <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                // A grant plus a new accept on one channel replaces the entry in place.
                if (flush) begin
                    buf_valid[c] <= 1'b0;
                end else if (bus.ch_valid_i[c] && ch_ready[c]) begin
                    buf_valid[c] <= 1'b1;
                    buf_wdata[c] <= bus.ch_wdata_i[c*DW +: DW];
                    buf_waddr[c] <= bus.ch_waddr_i[c*AW +: AW];
                    buf_long[c]  <= bus.ch_long_i[c];
                    buf_id[c]    <= bus.ch_id_i[c*IDW +: IDW];
                end else if (grant[c]) begin
                    buf_valid[c] <= 1'b0;
                end

                if (flush || !buf_valid[c] || grant[c]) begin
                    age[c] <= '0;
                end else if (age[c] != AGE_MAX) begin
                    age[c] <= age[c] + 1'b1;
                end
            end
        end
    end

`ifdef WBU_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;
        end
    end
`endif

    // x0 results still drain and may still commit, but never write the file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we       <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            commit_valid <= 1'b0;
            commit_id    <= '0;
        end else if (any_grant) begin
            reg_we       <= (buf_waddr[gidx] != '0);
            reg_waddr    <= buf_waddr[gidx];
            reg_wdata    <= buf_wdata[gidx];
            commit_valid <= buf_long[gidx];
            commit_id    <= buf_id[gidx];
        end else begin
            reg_we       <= 1'b0;
            commit_valid <= 1'b0;
        end
    end

    assign bus.ch_ready_o     = ch_ready;
    assign bus.reg_we_o       = reg_we;
    assign bus.reg_waddr_o    = reg_waddr;
    assign bus.reg_wdata_o    = reg_wdata;
    assign bus.commit_valid_o = commit_valid;
    assign bus.commit_id_o    = commit_id;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised N-channel register write-back arbiter for the alioth core. It sits between the EXU result sources (ALU, MULDIV, CSR, AGU/LSU, plus future units) and the integer register file write port. Each channel gets a one-entry holding buffer with a valid/ready handshake. Each cycle one buffered result is granted by fixed priority or round-robin arbitration, with age-based anti-starvation promotion. Register write and long-instruction commit outputs are registered.

## Interface
- NCH, 4, number of result channels (2..8); channel 0 is highest fixed priority
- DW, `REG_DATA_WIDTH, write data width
- AW, `REG_ADDR_WIDTH, register address width
- IDW, `COMMIT_ID_WIDTH, commit ID width
- STARVE_LIMIT, 7, waiting cycles before a buffered entry is promoted (>=1)
- clk  in  1  core clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- ch_valid_i  in  NCH  per-channel result valid
- ch_ready_o  out  NCH  per-channel buffer can accept
- ch_wdata_i  in  NCH*DW  packed write data; channel c at [c*DW +: DW]
- ch_waddr_i  in  NCH*AW  packed destination register
- ch_long_i  in  NCH  result belongs to a long instruction needing commit
- ch_id_i  in  NCH*IDW  packed commit ID; used only when ch_long_i is set
- flush_i  in  1  interrupt/flush; active level is `INT_ASSERT
- reg_we_o  out  1  register file write enable (registered)
- reg_waddr_o  out  AW  register file write address (registered)
- reg_wdata_o  out  DW  register file write data (registered)
- commit_valid_o  out  1  long-instruction completion (registered)
- commit_id_o  out  IDW  completed instruction ID (registered)

## Operation
- Per channel state: buf_valid, buf_wdata, buf_waddr, buf_long, buf_id, and an age counter of $clog2(STARVE_LIMIT+1) bits.
- ch_ready_o[c] = !flush && (!buf_valid[c] || grant[c]). This allows back-to-back acceptance at 1 result/cycle per channel while that channel is being granted.
- Accept: ch_valid_i[c] && ch_ready_o[c] loads the buffer at the clock edge.
- Candidate set = buf_valid. If any candidate has age == STARVE_LIMIT, grant the lowest-index starving candidate. Otherwise apply the mode arbiter (see Configuration).
- Exactly one grant per cycle when there is at least one candidate; grant is one-hot or zero.
- Age counter: increments when the entry is valid and not granted, saturating at STARVE_LIMIT. Clears on grant, on flush, or when the buffer is empty.
- Output registers load from the granted buffer:
  - reg_we_o = 1 unless waddr == 0. An x0 write is drained and granted but never writes.
  - commit_valid_o = buf_long of the granted entry.
- No grant: reg_we_o and commit_valid_o load 0; reg_waddr_o, reg_wdata_o and commit_id_o hold their values.
- Flush: while flush_i is active, all ready outputs are 0 and there is no grant. At the edge, all buf_valid and ages clear, and reg_we_o and commit_valid_o load 0. The RR pointer is preserved.

## Timing
- Reset (async, immediate): all buffers invalid, ages 0, RR pointer 0; reg_we_o, reg_waddr_o, reg_wdata_o, commit_valid_o, commit_id_o all 0. ch_ready_o is all ones once flush_i is inactive.
- Latency, uncontended: valid at cycle 0 → buffered at edge 0/1 → granted in cycle 1 → reg_we_o high in cycle 2.
- Sustained throughput: 1 write per cycle in total, across all channels.
- Worst-case wait for any entry: STARVE_LIMIT + NCH − 1 cycles.
- Simultaneous grant and new accept on the same channel: the buffer is replaced in place, with no bubble.
- Flush coincident with a grant: the flush wins; there is no output write.
- Reset mid-operation discards all buffered results.

## Configuration
- WBU_RR_EN defined: round-robin mode.
  - Search starts at rr_ptr and wraps modulo NCH.
  - After any grant g (including a starvation grant), rr_ptr ← (g+1) mod NCH, so NCH−1 wraps to 0.
- WBU_RR_EN undefined: fixed priority, lowest index wins.
  - No rr_ptr register exists.
  - Starvation promotion still applies.

## Test plan
- Reset, idle:
  - Assert rst_n=0 mid-cycle → all outputs 0 immediately; ch_ready_o=4'b1111 after release.
- Single write:
  - ch1 valid, waddr=5, wdata=0xDEADBEEF, long=1, id=3 → reg_we_o=1, waddr 5, data 0xDEADBEEF, commit_valid_o=1, commit_id_o=3, two cycles later.
- Contention, fixed mode:
  - ch0 and ch2 both valid continuously; ch0 refills every cycle → ch0 wins.
  - ch2 is granted in exactly cycle STARVE_LIMIT+1 after buffering (7 waits, then grant).
  - No write is lost or duplicated.
- Round-robin (WBU_RR_EN):
  - All 4 channels hold entries continuously → grants cycle 0,1,2,3,0.
  - rr_ptr wraps after channel 3.
- x0 write:
  - ch3 waddr=0, long=1, id=9 → reg_we_o=0, commit_valid_o=1, commit_id_o=9, buffer drained.
- Flush:
  - Entries in ch0 and ch1, flush_i asserted one cycle → both dropped, no reg_we_o/commit pulse, ch_ready_o=0 during flush, all ones the cycle after.
